// File: rtl/qam16_pkg.sv
// Shared QAM16 definitions used by both the transmitter and the receiver:
// FSM state encoding, Gray level table and tail length.
package qam16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_TAIL     = 2'd3
   } tx_state_t;

   localparam int TAIL_LEN = 4;

   // Level as a multiple of the unit amplitude, indexed by the 2-bit Gray code
   localparam int GRAY_LEVEL [4] = '{-3, -1, 3, 1};

   localparam logic [1:0] GRAY_POS3 = 2'b10;
   localparam logic [1:0] GRAY_NEG3 = 2'b00;

   function automatic logic signed [13:0] gray_level(input logic [1:0] code, input int amp);
      return 14'(GRAY_LEVEL[code] * amp);
   endfunction

endpackage

// File: rtl/qam16_mapper.sv
// Combinational Gray mapper: one 2-bit code to one signed 14-bit DAC level.
module qam16_mapper
   import qam16_pkg::*;
#(
   parameter int AMP = 1024
)
(
   input  logic [1:0]         code,
   output logic signed [13:0] level
);

   assign level = gray_level(code, AMP);

endmodule

// File: rtl/qam16_symbol_tx.sv
// QAM16 symbol transmitter: framed preamble, Gray-mapped payload nibbles and a
// zero tail, each symbol held for SPS clocks on the I/Q DAC outputs.
module qam16_symbol_tx
   import qam16_pkg::*;
#(
   parameter int SPS         = 8,
   parameter int PRE_LEN     = 16,
   parameter int FRAME_BYTES = 64,
   parameter int AMP         = 1024
)
(
   input  logic               CLK,
   input  logic               Rst,
   input  logic               Start,
   input  logic [7:0]         S_DATA,
   input  logic               S_VALID,
   output logic               S_READY,
   output logic signed [13:0] DA,
   output logic signed [13:0] DB,
   output logic               SYM_STB,
   output logic               BUSY,
   output logic               UNDERRUN
);

   tx_state_t          state_reg, state_next;
   logic [7:0]         phase_reg, phase_next;
   logic [15:0]        sym_cnt_reg, sym_cnt_next;
   logic [15:0]        nib_cnt_reg, nib_cnt_next;
   logic [15:0]        byte_cnt_reg, byte_cnt_next;
   logic [7:0]         hold_reg, hold_next;
   logic [1:0]         hold_cnt_reg, hold_cnt_next;
   logic signed [13:0] da_reg, da_next;
   logic signed [13:0] db_reg, db_next;
   logic               stb_reg, stb_next;
   logic               underrun_reg, underrun_next;

   logic [3:0]         sym_bits;
   logic               sym_zero;
   logic               accept;
   logic               sym_start;
   logic               sym_wrap;
   logic signed [13:0] lvl [2];

   // lvl[1] is the I level from sym_bits[3:2], lvl[0] the Q level from sym_bits[1:0]
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_map
         qam16_mapper #(.AMP(AMP)) u_mapper (
            .code  (sym_bits[2*gi +: 2]),
            .level (lvl[gi])
         );
      end
   endgenerate

   assign S_READY   = (state_reg == ST_PAYLOAD) && (hold_cnt_reg == 2'd0) &&
                      (byte_cnt_reg < 16'(FRAME_BYTES));
   assign accept    = S_VALID && S_READY;
   assign sym_start = (phase_reg == 8'd0);
   assign sym_wrap  = (phase_reg == 8'(SPS - 1));

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         state_reg    <= ST_IDLE;
         phase_reg    <= '0;
         sym_cnt_reg  <= '0;
         nib_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         hold_reg     <= '0;
         hold_cnt_reg <= '0;
         da_reg       <= '0;
         db_reg       <= '0;
         stb_reg      <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         sym_cnt_reg  <= sym_cnt_next;
         nib_cnt_reg  <= nib_cnt_next;
         byte_cnt_reg <= byte_cnt_next;
         hold_reg     <= hold_next;
         hold_cnt_reg <= hold_cnt_next;
         da_reg       <= da_next;
         db_reg       <= db_next;
         stb_reg      <= stb_next;
         underrun_reg <= underrun_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      phase_next    = sym_wrap ? 8'd0 : phase_reg + 8'd1;
      sym_cnt_next  = sym_cnt_reg;
      nib_cnt_next  = nib_cnt_reg;
      byte_cnt_next = byte_cnt_reg;
      hold_next     = hold_reg;
      hold_cnt_next = hold_cnt_reg;
      da_next       = da_reg;
      db_next       = db_reg;
      stb_next      = 1'b0;
      underrun_next = underrun_reg;
      sym_bits      = 4'b0000;
      sym_zero      = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            phase_next = 8'd0;
            da_next    = '0;
            db_next    = '0;
            if (Start) begin
               state_next    = ST_PREAMBLE;
               sym_cnt_next  = '0;
               nib_cnt_next  = '0;
               byte_cnt_next = '0;
               hold_next     = '0;
               hold_cnt_next = '0;
               underrun_next = 1'b0;
            end
         end

         ST_PREAMBLE: begin
            if (sym_start) begin
               stb_next = 1'b1;
               sym_zero = 1'b0;
               sym_bits = sym_cnt_reg[0] ? {GRAY_NEG3, GRAY_NEG3} : {GRAY_POS3, GRAY_POS3};
            end
            if (sym_wrap) begin
               if (sym_cnt_reg == 16'(PRE_LEN - 1)) begin
                  state_next   = ST_PAYLOAD;
                  sym_cnt_next = '0;
               end else begin
                  sym_cnt_next = sym_cnt_reg + 16'd1;
               end
            end
         end

         ST_PAYLOAD: begin
            if (accept) begin
               byte_cnt_next = byte_cnt_reg + 16'd1;
               hold_next     = S_DATA;
               hold_cnt_next = 2'd2;
            end
            // A byte arriving on the symbol's first clock is forwarded straight to the mapper
            if (sym_start) begin
               stb_next = 1'b1;
               if (hold_cnt_reg == 2'd2) begin
                  sym_bits      = hold_reg[7:4];
                  sym_zero      = 1'b0;
                  hold_cnt_next = 2'd1;
                  nib_cnt_next  = nib_cnt_reg + 16'd1;
               end else if (hold_cnt_reg == 2'd1) begin
                  sym_bits      = hold_reg[3:0];
                  sym_zero      = 1'b0;
                  hold_cnt_next = 2'd0;
                  nib_cnt_next  = nib_cnt_reg + 16'd1;
               end else if (accept) begin
                  sym_bits      = S_DATA[7:4];
                  sym_zero      = 1'b0;
                  hold_cnt_next = 2'd1;
                  nib_cnt_next  = nib_cnt_reg + 16'd1;
               end else begin
                  underrun_next = 1'b1;
               end
            end
            if (sym_wrap && (nib_cnt_reg == 16'(2 * FRAME_BYTES))) begin
               state_next   = ST_TAIL;
               sym_cnt_next = '0;
            end
         end

         ST_TAIL: begin
            if (sym_start) begin
               stb_next = 1'b1;
            end
            if (sym_wrap) begin
               if (sym_cnt_reg == 16'(TAIL_LEN - 1)) begin
                  state_next = ST_IDLE;
               end else begin
                  sym_cnt_next = sym_cnt_reg + 16'd1;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
            phase_next = 8'd0;
            da_next    = '0;
            db_next    = '0;
         end
      endcase

      if (stb_next) begin
         da_next = sym_zero ? 14'sd0 : lvl[1];
         db_next = sym_zero ? 14'sd0 : lvl[0];
      end
   end

   assign DA       = da_reg;
   assign DB       = db_reg;
   assign SYM_STB  = stb_reg;
   assign BUSY     = (state_reg != ST_IDLE);
   assign UNDERRUN = underrun_reg;

endmodule

// File: tb/tb_qam16_symbol_tx.sv
// Self-checking bench for qam16_symbol_tx: random payload bytes and source gaps,
// checked against a symbol-level reference built from the Gray rules.
module tb_qam16_symbol_tx;

   localparam int SPS         = 8;
   localparam int PRE_LEN     = 16;
   localparam int FRAME_BYTES = 64;
   localparam int AMP         = 1024;
   localparam int BUDGET      = 20000;

   logic               CLK = 1'b0;
   logic               Rst;
   logic               Start;
   logic [7:0]         S_DATA;
   logic               S_VALID;
   logic               S_READY;
   logic signed [13:0] DA;
   logic signed [13:0] DB;
   logic               SYM_STB;
   logic               BUSY;
   logic               UNDERRUN;

   int compared   = 0;
   int mismatched = 0;

   always #5 CLK = ~CLK;

   qam16_symbol_tx #(
      .SPS         (SPS),
      .PRE_LEN     (PRE_LEN),
      .FRAME_BYTES (FRAME_BYTES),
      .AMP         (AMP)
   ) dut (
      .CLK      (CLK),
      .Rst      (Rst),
      .Start    (Start),
      .S_DATA   (S_DATA),
      .S_VALID  (S_VALID),
      .S_READY  (S_READY),
      .DA       (DA),
      .DB       (DB),
      .SYM_STB  (SYM_STB),
      .BUSY     (BUSY),
      .UNDERRUN (UNDERRUN)
   );

   // Gray decode: 00,01,11,10 are the levels -3,-1,+1,+3 times AMP
   function automatic int level_of(input logic [1:0] b);
      int n;
      n = (b[1] ? 2 : 0) + ((b[1] ^ b[0]) ? 1 : 0);
      return (2 * n - 3) * AMP;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: source always valid; 1: one stall spanning exactly 3 empty symbols;
   // 2: sparse random valid. abort_at>0 pulses Rst after that many payload nibbles.
   task automatic run_frame(input string name, input int mode, input bit poke,
                            input int abort_at, input bit chk_b4);
      int cyc, sym_idx, nonzero, zeros, tails, gap, first_stb;
      int hold_err, gap_err, tail_err, stall_state, bytes_acc, exp_lvl;
      int pay_da [2];
      int pay_db [2];
      logic [3:0] nib_q [$];
      logic [3:0] nib;
      logic [7:0] cur_byte;
      logic hs_pending, poked;
      logic signed [13:0] prev_da, prev_db;

      cyc = 1; sym_idx = 0; nonzero = 0; zeros = 0; tails = 0; gap = 0; first_stb = 0;
      hold_err = 0; gap_err = 0; tail_err = 0; stall_state = 0; bytes_acc = 0;
      pay_da = '{0, 0}; pay_db = '{0, 0};
      cur_byte = chk_b4 ? 8'hB4 : 8'($urandom);
      hs_pending = 1'b0; poked = 1'b0;
      prev_da = '0; prev_db = '0;

      Start = 1'b1;
      S_VALID = 1'b0;
      @(negedge CLK);
      Start = 1'b0;
      check({name, " busy after start"}, BUSY, 1);
      check({name, " underrun cleared by start"}, UNDERRUN, 0);

      while (cyc < BUDGET) begin
         if (hs_pending) begin
            nib_q.push_back(cur_byte[7:4]);
            nib_q.push_back(cur_byte[3:0]);
            bytes_acc++;
            cur_byte = 8'($urandom);
         end
         if (SYM_STB === 1'b1) begin
            if (first_stb == 0) first_stb = cyc;
            else if (gap != SPS) gap_err++;
            gap = 0;
            if (sym_idx < PRE_LEN) begin
               exp_lvl = (sym_idx % 2 == 0) ? 3 * AMP : -3 * AMP;
               check($sformatf("%s preamble %0d I", name, sym_idx), DA, exp_lvl);
               check($sformatf("%s preamble %0d Q", name, sym_idx), DB, exp_lvl);
            end else if (nonzero < 2 * FRAME_BYTES) begin
               if (DA === 14'sd0 && DB === 14'sd0) begin
                  zeros++;
               end else begin
                  check($sformatf("%s nibble available %0d", name, nonzero), nib_q.size() > 0, 1);
                  nib = (nib_q.size() > 0) ? nib_q.pop_front() : 4'h0;
                  check($sformatf("%s payload %0d I", name, nonzero), DA, level_of(nib[3:2]));
                  check($sformatf("%s payload %0d Q", name, nonzero), DB, level_of(nib[1:0]));
                  if (nonzero < 2) begin
                     pay_da[nonzero] = int'(DA);
                     pay_db[nonzero] = int'(DB);
                  end
                  nonzero++;
               end
            end else begin
               tails++;
               if (DA !== 14'sd0 || DB !== 14'sd0) tail_err++;
            end
            sym_idx++;
         end else if (BUSY === 1'b1 && (DA !== prev_da || DB !== prev_db)) begin
            hold_err++;
         end
         prev_da = DA;
         prev_db = DB;
         gap++;
         if (BUSY !== 1'b1) break;

         if (abort_at > 0 && nonzero == abort_at) begin
            #2 Rst = 1'b1;
            #1;
            check({name, " async reset DA"}, DA, 0);
            check({name, " async reset DB"}, DB, 0);
            check({name, " async reset BUSY"}, BUSY, 0);
            check({name, " async reset SYM_STB"}, SYM_STB, 0);
            check({name, " async reset S_READY"}, S_READY, 0);
            check({name, " async reset UNDERRUN"}, UNDERRUN, 0);
            @(negedge CLK);
            Rst = 1'b0;
            S_VALID = 1'b0;
            Start = 1'b0;
            return;
         end

         Start = 1'b0;
         if (poke && !poked && sym_idx == PRE_LEN + 6) begin
            Start = 1'b1;
            poked = 1'b1;
         end
         case (mode)
            0: S_VALID = 1'b1;
            1: begin
               if (stall_state == 0) begin
                  S_VALID = 1'b1;
                  if (bytes_acc >= 10) begin
                     stall_state = 1;
                     S_VALID = 1'b0;
                  end
               end else if (stall_state == 1) begin
                  S_VALID = 1'b0;
                  if (zeros == 3) begin
                     stall_state = 2;
                     S_VALID = 1'b1;
                  end
               end else begin
                  S_VALID = 1'b1;
               end
            end
            default: S_VALID = ($urandom_range(0, 15) == 0);
         endcase
         S_DATA = cur_byte;
         hs_pending = S_VALID && S_READY;
         @(negedge CLK);
         cyc++;
      end
      S_VALID = 1'b0;

      check({name, " frame ended within budget"}, BUSY, 0);
      check({name, " first symbol latency"}, first_stb, 2);
      check({name, " payload symbols"}, nonzero, 2 * FRAME_BYTES);
      check({name, " bytes accepted"}, bytes_acc, FRAME_BYTES);
      check({name, " nibbles left unsent"}, nib_q.size(), 0);
      check({name, " tail symbols"}, tails, 4);
      check({name, " tail nonzero"}, tail_err, 0);
      check({name, " symbol hold errors"}, hold_err, 0);
      check({name, " strobe spacing errors"}, gap_err, 0);
      check({name, " ready after frame"}, S_READY, 0);
      check({name, " DA after frame"}, DA, 0);
      if (mode == 0) begin
         check({name, " zero symbols"}, zeros, 0);
         check({name, " underrun flag"}, UNDERRUN, 0);
      end else if (mode == 1) begin
         check({name, " zero symbols"}, zeros, 3);
         check({name, " underrun flag"}, UNDERRUN, 1);
      end else begin
         check({name, " underrun flag"}, UNDERRUN, (zeros > 0) ? 1 : 0);
      end
      if (chk_b4) begin
         check({name, " 0xB4 sym0 I"}, pay_da[0], 3072);
         check({name, " 0xB4 sym0 Q"}, pay_db[0], 1024);
         check({name, " 0xB4 sym1 I"}, pay_da[1], -1024);
         check({name, " 0xB4 sym1 Q"}, pay_db[1], -3072);
      end
      $display("frame %s: %0d payload, %0d zero, %0d tail symbols", name, nonzero, zeros, tails);
   endtask

   initial begin
      Rst = 1'b1;
      Start = 1'b0;
      S_VALID = 1'b0;
      S_DATA = 8'h00;
      repeat (3) @(negedge CLK);
      check("reset DA", DA, 0);
      check("reset DB", DB, 0);
      check("reset SYM_STB", SYM_STB, 0);
      check("reset S_READY", S_READY, 0);
      check("reset BUSY", BUSY, 0);
      check("reset UNDERRUN", UNDERRUN, 0);
      Rst = 1'b0;
      @(negedge CLK);
      check("idle BUSY", BUSY, 0);
      check("idle SYM_STB", SYM_STB, 0);

      run_frame("A_cont_b4_poke", 0, 1'b1, 0, 1'b1);
      run_frame("B_stall", 1, 1'b0, 0, 1'b0);
      run_frame("C_random", 2, 1'b0, 0, 1'b0);
      run_frame("D_abort", 2, 1'b0, 20, 1'b0);
      run_frame("E_restart", 0, 1'b0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/qam16_symbol_tx.md
QAM16_SYMBOL_TX -- requirements
Module: qam16_symbol_tx

Interface
REQ-001 SHALL have parameter SPS, default 8, giving clocks per symbol (range 2..255).
REQ-002 SHALL have parameter PRE_LEN, default 16, giving the number of preamble symbols per frame.
REQ-003 SHALL have parameter FRAME_BYTES, default 64, giving payload bytes per frame.
REQ-004 SHALL have parameter AMP, default 1024, giving the unit level; 3*AMP must fit 14-bit signed.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port Start, input, 1 bit: frame request pulse.
REQ-008 SHALL have port S_DATA, input, 8 bits: payload byte.
REQ-009 SHALL have port S_VALID, input, 1 bit: S_DATA valid.
REQ-010 SHALL have port S_READY, output, 1 bit: byte accepted when S_VALID and S_READY are both high on a CLK edge.
REQ-011 SHALL have port DA, output, 14 bits signed: I baseband sample to DAC.
REQ-012 SHALL have port DB, output, 14 bits signed: Q baseband sample to DAC.
REQ-013 SHALL have port SYM_STB, output, 1 bit: high on the first clock of every emitted symbol.
REQ-014 SHALL have port BUSY, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port UNDERRUN, output, 1 bit: sticky payload-starvation flag.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, PAYLOAD, TAIL.
REQ-017 In IDLE, DA=DB=0 and SYM_STB=0; Start=1 SHALL move to PREAMBLE, with the first preamble symbol on DA/DB one clock later.
REQ-018 Every symbol SHALL be held on DA/DB for exactly SPS clocks (hold upsampling), counted by a symbol-phase counter wrapping at SPS-1.
REQ-019 Preamble symbol k (k=0..PRE_LEN-1) SHALL be (+3A,+3A) for even k and (-3A,-3A) for odd k.
REQ-020 After PRE_LEN symbols the state SHALL change to PAYLOAD at the symbol boundary.
REQ-021 Each byte SHALL yield two symbols, high nibble first; nibble bits [3:2] select I and [1:0] select Q.
REQ-022 Gray map per 2 bits SHALL be 00->-3A, 01->-A, 11->+A, 10->+3A.
REQ-023 A one-byte holding register SHALL buffer input; S_READY=1 only in PAYLOAD while that register is empty and fewer than FRAME_BYTES bytes have been accepted in the frame.
REQ-024 If a symbol boundary in PAYLOAD needs a nibble and none is buffered, DA=DB=0 SHALL be emitted for that symbol, UNDERRUN SHALL set, and the missing nibble SHALL not be skipped (sent at a later symbol).
REQ-025 After 2*FRAME_BYTES payload symbols, the state SHALL go to TAIL and emit 4 zero symbols, then IDLE.
REQ-026 Start SHALL be ignored while BUSY=1.
REQ-027 Start in IDLE SHALL clear UNDERRUN.

Reset
REQ-028 Rst=1 SHALL asynchronously force IDLE, DA=DB=0, SYM_STB=0, S_READY=0, BUSY=0, UNDERRUN=0, clear all counters and the holding register, including mid-frame.

Structure
REQ-029 State encoding, the Gray level table and the TAIL length (4) SHALL reside in shared package qam16_pkg, reused by the receiver.
REQ-030 Gray nibble-to-level mapping SHALL be sub-module qam16_mapper (combinational, 2 bits -> 14-bit level).

Verification
REQ-031 Start, SPS=8, PRE_LEN=16 -> 128 clocks alternating +3072/-3072 on DA and DB, SYM_STB every 8 clocks.
REQ-032 Payload byte 0xB4 after preamble -> symbols (I=+3072,Q=+1024) then (I=-1024,Q=-3072), each held 8 clocks.
REQ-033 S_VALID held low for 3 symbol periods in PAYLOAD -> 3 zero symbols, UNDERRUN=1, no payload nibble lost.
REQ-034 Full frame of 64 bytes -> exactly 128 payload symbols, 4 zero TAIL symbols, then BUSY=0 and S_READY=0.
REQ-035 Rst pulsed mid-PAYLOAD -> same edge DA=DB=0, BUSY=0; next Start restarts with preamble symbol 0.
REQ-036 Start asserted during PAYLOAD -> ignored, frame length unchanged.
